// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM/WB-to-register-file bundle for the writeback stage
interface wb_stage_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       WB;
    logic [31:0]      PC4;
    logic [31:0]      memData;
    logic [31:0]      res;
    logic [2:0]       RCT;
    logic [31:0]      inst;
    logic [31:0]      hilo;
    logic             hold;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic             fwd_valid;
    logic [4:0]       fwd_addr;
    logic [31:0]      fwd_data;
    logic [CNT_W-1:0] retired;

    modport master (
        output WB, PC4, memData, res, RCT, inst, hilo, hold,
        input  rf_we, rf_waddr, rf_wdata, hi, lo,
        input  fwd_valid, fwd_addr, fwd_data, retired
    );

    modport slave (
        input  WB, PC4, memData, res, RCT, inst, hilo, hold,
        output rf_we, rf_waddr, rf_wdata, hi, lo,
        output fwd_valid, fwd_addr, fwd_data, retired
    );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: register-file write port, HI/LO, bypass latch, retire counter
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    wb_stage_if.slave wb
);
    localparam logic [1:0] SEL_RES  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    localparam logic [2:0] LD_BS = 3'b001;
    localparam logic [2:0] LD_BU = 3'b010;
    localparam logic [2:0] LD_HS = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    localparam logic [5:0] FUNCT_MFHI = 6'h10;

    logic             reg_write;
    logic [1:0]       data_sel;
    logic             hi_write;
    logic             lo_write;
    logic             link;

    logic [4:0]       waddr;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_val;
    logic [31:0]      wdata;
    logic             we;

    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             fwd_valid_q, fwd_valid_d;
    logic [4:0]       fwd_addr_q, fwd_addr_d;
    logic [31:0]      fwd_data_q, fwd_data_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic             unused_inst_bits;

    assign reg_write = wb.WB[0];
    assign data_sel  = wb.WB[2:1];
    assign hi_write  = wb.WB[3];
    assign lo_write  = wb.WB[4];
    assign link      = wb.WB[5];

    assign unused_inst_bits = ^{wb.inst[25:21], wb.inst[10:6]};

    always_comb begin
        waddr = wb.inst[20:16];
        if (link) begin
            waddr = 5'd31;
        end else if (wb.inst[31:26] == 6'd0) begin
            waddr = wb.inst[15:11];
        end
    end

    // Little-endian lane selection; res[0] is ignored for halfwords.
    always_comb begin
        byte_sel = wb.memData[7:0];
        case (wb.res[1:0])
            2'd0:    byte_sel = wb.memData[7:0];
            2'd1:    byte_sel = wb.memData[15:8];
            2'd2:    byte_sel = wb.memData[23:16];
            default: byte_sel = wb.memData[31:24];
        endcase
        half_sel = wb.res[1] ? wb.memData[31:16] : wb.memData[15:0];
    end

    always_comb begin
        load_val = wb.memData;
        case (wb.RCT)
            LD_BS:   load_val = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   load_val = {24'd0, byte_sel};
            LD_HS:   load_val = {{16{half_sel[15]}}, half_sel};
            LD_HU:   load_val = {16'd0, half_sel};
            default: load_val = wb.memData;
        endcase
    end

    // HI/LO reads use the registered values: no same-cycle bypass from a preceding mt*.
    always_comb begin
        wdata = wb.res;
        case (data_sel)
            SEL_RES:  wdata = wb.res;
            SEL_LOAD: wdata = load_val;
            SEL_PC4:  wdata = wb.PC4;
            default:  wdata = (wb.inst[5:0] == FUNCT_MFHI) ? hi_q : lo_q;
        endcase
    end

    assign we = reg_write & ~wb.hold & (waddr != 5'd0);

    always_comb begin
        hi_d        = hi_q;
        lo_d        = lo_q;
        fwd_valid_d = fwd_valid_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        retired_d   = retired_q;
        if (!wb.hold) begin
            if (hi_write) begin
                hi_d = wb.hilo;
            end
            if (lo_write) begin
                lo_d = wb.res;
            end
            fwd_valid_d = we;
            fwd_addr_d  = waddr;
            fwd_data_d  = wdata;
            if (wb.inst != 32'd0) begin
                retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= 5'd0;
            fwd_data_q  <= 32'd0;
            retired_q   <= '0;
        end else begin
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
            retired_q   <= retired_d;
        end
    end

    assign wb.rf_we     = we;
    assign wb.rf_waddr  = waddr;
    assign wb.rf_wdata  = wdata;
    assign wb.hi        = hi_q;
    assign wb.lo        = lo_q;
    assign wb.fwd_valid = fwd_valid_q;
    assign wb.fwd_addr  = fwd_addr_q;
    assign wb.fwd_data  = fwd_data_q;
    assign wb.retired   = retired_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with a behavioural model
module tb_wb_stage;
    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic clk;
    logic rst;
    wb_stage_if #(.CNT_W(CNT_W)) bus ();

    wb_stage #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    int tests;
    int fails;
    bit chk_en;

    logic [31:0] m_hi, m_lo, m_fd;
    logic        m_fv;
    logic [4:0]  m_fa;
    int          m_ret;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected register-file write port derived from the field definitions.
    function automatic void model_rf(output logic we, output logic [4:0] a, output logic [31:0] d);
        logic [31:0] b, h;
        if (bus.WB[5])                    a = 5'd31;
        else if (bus.inst[31:26] == 6'd0) a = bus.inst[15:11];
        else                              a = bus.inst[20:16];
        b = (bus.memData >> (32'(bus.res[1:0]) * 8)) & 32'hFF;
        h = bus.res[1] ? (bus.memData >> 16) : (bus.memData & 32'hFFFF);
        case (bus.WB[2:1])
            2'd0: d = bus.res;
            2'd1: begin
                case (bus.RCT)
                    3'd1:    d = (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
                    3'd2:    d = b;
                    3'd3:    d = (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
                    3'd4:    d = h;
                    default: d = bus.memData;
                endcase
            end
            2'd2: d = bus.PC4;
            default: d = (bus.inst[5:0] == 6'h10) ? m_hi : m_lo;
        endcase
        we = bus.WB[0] && !bus.hold && (a != 5'd0);
    endfunction

    always @(posedge clk or negedge rst) begin
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        if (!rst) begin
            m_hi = 0; m_lo = 0; m_fv = 0; m_fa = 0; m_fd = 0; m_ret = 0;
        end else if (!bus.hold) begin
            model_rf(e_we, e_a, e_d);
            if (bus.WB[3]) m_hi = bus.hilo;
            if (bus.WB[4]) m_lo = bus.res;
            m_fv = e_we; m_fa = e_a; m_fd = e_d;
            if (bus.inst != 0) m_ret = (m_ret + 1) % CNT_MOD;
        end
    end

    always @(negedge clk) begin
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        if (chk_en) begin
            model_rf(e_we, e_a, e_d);
            check("rf_we", 32'(bus.rf_we), 32'(e_we));
            check("rf_waddr", 32'(bus.rf_waddr), 32'(e_a));
            check("rf_wdata", bus.rf_wdata, e_d);
            check("hi", bus.hi, m_hi);
            check("lo", bus.lo, m_lo);
            check("fwd_valid", 32'(bus.fwd_valid), 32'(m_fv));
            check("fwd_addr", 32'(bus.fwd_addr), 32'(m_fa));
            check("fwd_data", bus.fwd_data, m_fd);
            check("retired", 32'(bus.retired), 32'(m_ret));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] wbv, input logic [31:0] inst, input logic [31:0] res,
                         input logic [31:0] mem, input logic [2:0] rct, input logic [31:0] pc4,
                         input logic [31:0] hilo);
        bus.WB = wbv; bus.inst = inst; bus.res = res; bus.memData = mem;
        bus.RCT = rct; bus.PC4 = pc4; bus.hilo = hilo; bus.hold = 1'b0;
    endtask

    task automatic filler();
        drive(6'd0, 32'h00000020, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] s_hi, s_lo, s_fd;
        logic        s_fv;
        logic [4:0]  s_fa;
        int          s_ret;
        tests = 0; fails = 0; chk_en = 0;
        rst = 1'b0;
        drive(6'd0, 32'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
        tick(); tick();
        rst = 1'b1;
        chk_en = 1;

        // Build hi=5, retired=7 then reset mid-cycle
        drive(6'b001000, 32'h00400011, 32'd0, 32'd0, 3'd0, 32'd0, 32'd5);
        tick();
        filler();
        for (int i = 0; i < 20 && m_ret != 7; i++) tick();
        check("pre_reset_hi", bus.hi, 32'd5);
        check("pre_reset_retired", 32'(bus.retired), 32'd7);
        #1 rst = 1'b0;
        #1;
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        check("rst_fwd_addr", 32'(bus.fwd_addr), 32'd0);
        check("rst_fwd_data", bus.fwd_data, 32'd0);
        check("rst_retired", 32'(bus.retired), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("retired_restart", 32'(bus.retired), 32'd1);

        // Load extraction
        drive(6'b000011, 32'h8C020000, 32'd2, 32'h80FF7F01, 3'b001, 32'd0, 32'd0);
        #1 check("lb_k2", bus.rf_wdata, 32'hFFFFFFFF);
        check("lw_waddr", 32'(bus.rf_waddr), 32'd2);
        tick();
        drive(6'b000011, 32'h8C020000, 32'd3, 32'h80FF7F01, 3'b010, 32'd0, 32'd0);
        #1 check("lbu_k3", bus.rf_wdata, 32'h00000080);
        tick();
        drive(6'b000011, 32'h8C020000, 32'd2, 32'h80FF7F01, 3'b011, 32'd0, 32'd0);
        #1 check("lh_hi", bus.rf_wdata, 32'hFFFF80FF);
        tick();
        drive(6'b000011, 32'h8C020000, 32'd1, 32'h80FF7F01, 3'b100, 32'd0, 32'd0);
        #1 check("lhu_lo", bus.rf_wdata, 32'h00007F01);
        tick();
        drive(6'b000011, 32'h8C020000, 32'd3, 32'h80FF7F01, 3'b111, 32'd0, 32'd0);
        #1 check("lw_rct7", bus.rf_wdata, 32'h80FF7F01);
        tick();

        // Destination and link
        drive(6'b000001, 32'h00851020, 32'h11, 32'd0, 3'd0, 32'd0, 32'd0);
        #1 check("rtype_waddr", 32'(bus.rf_waddr), 32'd2);
        tick();
        drive(6'b000001, 32'h20A3000C, 32'h22, 32'd0, 3'd0, 32'd0, 32'd0);
        #1 check("itype_waddr", 32'(bus.rf_waddr), 32'd3);
        tick();
        drive(6'b100101, 32'h0C000010, 32'h33, 32'd0, 3'd0, 32'h40, 32'd0);
        #1 check("link_waddr", 32'(bus.rf_waddr), 32'd31);
        check("link_wdata", bus.rf_wdata, 32'h40);
        check("link_we", 32'(bus.rf_we), 32'd1);
        tick();
        drive(6'b000001, 32'h00000020, 32'h44, 32'd0, 3'd0, 32'd0, 32'd0);
        #1 check("r0_we", 32'(bus.rf_we), 32'd0);
        tick();

        // HI/LO write then mfhi/mflo
        drive(6'b011000, 32'h00850018, 32'hB, 32'd0, 3'd0, 32'd0, 32'hA);
        tick();
        check("mult_hi", bus.hi, 32'hA);
        check("mult_lo", bus.lo, 32'hB);
        drive(6'b000111, 32'h00001010, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
        #1 check("mfhi", bus.rf_wdata, 32'hA);
        tick();
        drive(6'b000111, 32'h00001012, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
        #1 check("mflo", bus.rf_wdata, 32'hB);
        tick();

        // Hold with a valid write present
        drive(6'b011001, 32'h00851020, 32'h1234, 32'd0, 3'd0, 32'd0, 32'h5678);
        bus.hold = 1'b1;
        s_hi = m_hi; s_lo = m_lo; s_fv = m_fv; s_fa = m_fa; s_fd = m_fd; s_ret = m_ret;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_we", 32'(bus.rf_we), 32'd0);
            tick();
            check("hold_hi", bus.hi, s_hi);
            check("hold_lo", bus.lo, s_lo);
            check("hold_fwd_valid", 32'(bus.fwd_valid), 32'(s_fv));
            check("hold_fwd_addr", 32'(bus.fwd_addr), 32'(s_fa));
            check("hold_fwd_data", bus.fwd_data, s_fd);
            check("hold_retired", 32'(bus.retired), 32'(s_ret));
        end
        bus.hold = 1'b0;
        tick();
        check("hold_release_retired", 32'(bus.retired), 32'((s_ret + 1) % CNT_MOD));
        check("hold_release_fwd", bus.fwd_data, 32'h1234);
        check("hold_release_hi", bus.hi, 32'h5678);

        // Counter wrap and bypass latch
        filler();
        for (int i = 0; i < 20 && m_ret != CNT_MOD - 1; i++) tick();
        check("pre_wrap", 32'(bus.retired), 32'(CNT_MOD - 1));
        drive(6'b000001, 32'h00851020, 32'h77, 32'd0, 3'd0, 32'd0, 32'd0);
        tick();
        check("wrap_retired", 32'(bus.retired), 32'd0);
        check("wrap_fwd_valid", 32'(bus.fwd_valid), 32'd1);
        check("wrap_fwd_addr", 32'(bus.fwd_addr), 32'd2);
        check("wrap_fwd_data", bus.fwd_data, 32'h77);
        drive(6'd0, 32'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
        tick();
        check("bubble_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        check("bubble_retired", 32'(bus.retired), 32'd0);
        tick();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
